polyvecl_caddq_seq: RTL

- Sequential conditional-add-q engine for a length-L polynomial vector (L=5 polys × 256 coeffs × 32-bit signed, 40960-bit bus).
- Maps each coefficient from the centred range produced by the vector reduce stage to the standard representative [0, Q). It runs a[i] + Q when a[i] < 0, else a[i].
- Sits after the reduce stage, ahead of packing/hashing.
- Processes LANES coefficients per cycle under a start/busy/done handshake, so area does not scale with the vector width.

---
 rtl/polyvecl_caddq_seq_if.sv | 15 +
 rtl/polyvecl_caddq_seq.sv | 77 +++++++
 2 files changed

// File: rtl/polyvecl_caddq_seq_if.sv
// Handshake and vector bus for the sequential conditional-add-q engine.
interface polyvecl_caddq_seq_if #(
   parameter int W = 40960
);
   logic         start;
   logic [W-1:0] v_in;
   logic         busy;
   logic         done;
   logic [W-1:0] v_out;

   // Requester side: issues start and supplies the vector.
   modport master (output start, output v_in, input busy, input done, input v_out);
   // Engine side.
   modport slave  (input start, input v_in, output busy, output done, output v_out);
endinterface

// File: rtl/polyvecl_caddq_seq.sv
// Sequential conditional-add-q over a length-L polynomial vector.
// Each RUN cycle maps LANES coefficients of the captured vector from the
// centred range to [0, Q) by adding Q to negatives, writing them into v_out.
module polyvecl_caddq_seq #(
   parameter int L     = 5,
   parameter int N     = 256,
   parameter int LANES = 8,
   parameter int Q     = 8380417
) (
   input  logic                 clk,
   input  logic                 rst,
   polyvecl_caddq_seq_if.slave  bus
);
   localparam int W   = L * N * 32;
   localparam int G   = (L * N) / LANES;
   localparam int GW  = LANES * 32;
   localparam int IW  = (G > 1) ? $clog2(G) : 1;
   localparam logic [31:0] Q32  = 32'(Q);
   localparam logic [IW-1:0] LAST = IW'(G - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q;
   logic [W-1:0]  work_q;
   logic [W-1:0]  vout_q;
   logic [GW-1:0] grp_src;
   logic [GW-1:0] grp_res;

   // Current group slice of the captured vector.
   assign grp_src = work_q[idx_q*GW +: GW];

   // Per-lane add of Q masked by the sign bit; plain 32-bit wrap, no saturation.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [31:0] a;
      assign a = grp_src[i*32 +: 32];
      assign grp_res[i*32 +: 32] = a + (Q32 & {32{a[31]}});
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: start only honoured in IDLE, DONE lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (idx_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: capture on accepted start, write one group per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         work_q <= '0;
         vout_q <= '0;
      end else begin
         if (state_q == IDLE && bus.start) begin
            work_q <= bus.v_in;
            idx_q  <= '0;
         end else if (state_q == RUN) begin
            vout_q[idx_q*GW +: GW] <= grp_res;
            idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
         end
      end
   end

   assign bus.busy  = (state_q == RUN);
   assign bus.done  = (state_q == DONE);
   assign bus.v_out = vout_q;
endmodule
